// File: rtl/s32x_fb_arbiter_pkg.sv
// Shared types and defaults for the 32X framebuffer bank arbiter.
package s32x_fb_arbiter_pkg;

    typedef enum logic [1:0] {
        FBARB_DISP = 2'd0,
        FBARB_FILL = 2'd1,
        FBARB_WR   = 2'd2,
        FBARB_RD   = 2'd3
    } FBARB_SRC_t;

    typedef enum logic {
        FBARB_IDLE = 1'b0,
        FBARB_SLOT = 1'b1
    } FBARB_ST_t;

    localparam int FBARB_ACC_CYC_DEF = 3;
    localparam int FBARB_STARVE_DEF  = 15;

endpackage

// File: rtl/s32x_fb_arb_pick.sv
// Combinational priority picker: DISP > FILL > WR > RD, or DISP > RD > FILL > WR
// while the starve flag is raised. Requests in the exclude mask are ignored.
module s32x_fb_arb_pick
    import s32x_fb_arbiter_pkg::*;
(
    input  logic [3:0]  req_i,
    input  logic [3:0]  excl_i,
    input  logic        starve_i,
    output logic        vld_o,
    output FBARB_SRC_t  src_o
);

    logic [3:0] cand;

    assign cand = req_i & ~excl_i;

    always_comb begin
        vld_o = |cand;
        src_o = FBARB_DISP;
        if (cand[0]) begin
            src_o = FBARB_DISP;
        end else if (starve_i && cand[3]) begin
            src_o = FBARB_RD;
        end else if (cand[1]) begin
            src_o = FBARB_FILL;
        end else if (cand[2]) begin
            src_o = FBARB_WR;
        end else if (cand[3]) begin
            src_o = FBARB_RD;
        end
    end

endmodule

// File: rtl/s32x_fb_arbiter.sv
// Framebuffer bank arbiter: four requesters share one DRAM port in fixed-length slots.
// Define S32X_FB_ARB_STARVE_EN to promote long-waiting CPU reads above FILL/WR.
module s32x_fb_arbiter
    import s32x_fb_arbiter_pkg::*;
#(
    parameter int ACC_CYC    = FBARB_ACC_CYC_DEF,
    parameter int STARVE_MAX = FBARB_STARVE_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        disp_req_i,
    input  logic        fill_req_i,
    input  logic        wr_req_i,
    input  logic        rd_req_i,
    input  logic [15:0] disp_a_i,
    input  logic [15:0] fill_a_i,
    input  logic [15:0] wr_a_i,
    input  logic [15:0] rd_a_i,
    input  logic [15:0] fill_d_i,
    input  logic [15:0] wr_d_i,
    input  logic [1:0]  fill_we_i,
    input  logic [1:0]  wr_we_i,
    output logic        disp_ack_o,
    output logic        fill_ack_o,
    output logic        wr_ack_o,
    output logic        rd_ack_o,
    output logic [15:0] disp_q_o,
    output logic [15:0] rd_q_o,
    output logic [15:0] mem_a_o,
    output logic [15:0] mem_d_o,
    output logic [1:0]  mem_we_o,
    output logic        mem_rd_o,
    input  logic [15:0] mem_q_i,
    output logic        busy_o,
    output logic [1:0]  gnt_id_o
);

    localparam logic [2:0] CNT_LOAD = 3'(ACC_CYC - 1);

    FBARB_ST_t   state_q, state_d;
    FBARB_SRC_t  gnt_q, gnt_d, pick_src;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] mem_a_q, mem_a_d, mem_dat_q, mem_dat_d;
    logic [1:0]  mem_we_q, mem_we_d;
    logic        mem_rd_q, mem_rd_d;
    logic [3:0]  ack_q, ack_d;
    logic [15:0] disp_q_q, disp_q_d, rd_q_q, rd_q_d;
    logic [3:0]  req_v, excl;
    logic        slot_done, arb_en, pick_vld, starve;

    assign req_v     = {rd_req_i, wr_req_i, fill_req_i, disp_req_i};
    assign slot_done = (state_q == FBARB_SLOT) && (cnt_q == 3'd0);
    assign arb_en    = (state_q == FBARB_IDLE) || slot_done;
    // The finishing grantee sits out the arbitration at its own completion edge.
    assign excl      = slot_done ? (4'b0001 << gnt_q) : 4'b0000;

    s32x_fb_arb_pick u_pick (
        .req_i    (req_v),
        .excl_i   (excl),
        .starve_i (starve),
        .vld_o    (pick_vld),
        .src_o    (pick_src)
    );

`ifdef S32X_FB_ARB_STARVE_EN
    logic [3:0] rd_wait_q, rd_wait_d;
    logic       rd_served;

    assign starve    = (rd_wait_q == 4'(STARVE_MAX));
    assign rd_served = (state_q == FBARB_SLOT) && (gnt_q == FBARB_RD);

    always_comb begin
        rd_wait_d = rd_wait_q;
        if (arb_en && pick_vld && (pick_src == FBARB_RD)) begin
            rd_wait_d = 4'd0;
        end else if (rd_req_i && !rd_served && !starve) begin
            rd_wait_d = rd_wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_wait_q <= 4'd0;
        end else begin
            rd_wait_q <= rd_wait_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        mem_a_d   = mem_a_q;
        mem_dat_d = mem_dat_q;
        mem_we_d  = mem_we_q;
        mem_rd_d  = mem_rd_q;
        ack_d     = 4'b0000;
        disp_q_d  = disp_q_q;
        rd_q_d    = rd_q_q;

        if ((state_q == FBARB_SLOT) && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end

        if (slot_done) begin
            ack_d[gnt_q] = 1'b1;
            if (gnt_q == FBARB_DISP) disp_q_d = mem_q_i;
            if (gnt_q == FBARB_RD)   rd_q_d   = mem_q_i;
        end

        if (arb_en) begin
            if (pick_vld) begin
                state_d = FBARB_SLOT;
                gnt_d   = pick_src;
                cnt_d   = CNT_LOAD;
                case (pick_src)
                    FBARB_DISP: begin
                        mem_a_d   = disp_a_i;
                        mem_dat_d = 16'h0000;
                        mem_we_d  = 2'b00;
                        mem_rd_d  = 1'b1;
                    end
                    FBARB_FILL: begin
                        mem_a_d   = fill_a_i;
                        mem_dat_d = fill_d_i;
                        mem_we_d  = fill_we_i;
                        mem_rd_d  = 1'b0;
                    end
                    FBARB_WR: begin
                        mem_a_d   = wr_a_i;
                        mem_dat_d = wr_d_i;
                        mem_we_d  = wr_we_i;
                        mem_rd_d  = 1'b0;
                    end
                    default: begin
                        mem_a_d   = rd_a_i;
                        mem_dat_d = 16'h0000;
                        mem_we_d  = 2'b00;
                        mem_rd_d  = 1'b1;
                    end
                endcase
            end else begin
                state_d   = FBARB_IDLE;
                mem_a_d   = 16'h0000;
                mem_dat_d = 16'h0000;
                mem_we_d  = 2'b00;
                mem_rd_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= FBARB_IDLE;
            gnt_q     <= FBARB_DISP;
            cnt_q     <= 3'd0;
            mem_a_q   <= 16'h0000;
            mem_dat_q <= 16'h0000;
            mem_we_q  <= 2'b00;
            mem_rd_q  <= 1'b0;
            ack_q     <= 4'b0000;
            disp_q_q  <= 16'h0000;
            rd_q_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            mem_a_q   <= mem_a_d;
            mem_dat_q <= mem_dat_d;
            mem_we_q  <= mem_we_d;
            mem_rd_q  <= mem_rd_d;
            ack_q     <= ack_d;
            disp_q_q  <= disp_q_d;
            rd_q_q    <= rd_q_d;
        end
    end

    assign disp_ack_o = ack_q[0];
    assign fill_ack_o = ack_q[1];
    assign wr_ack_o   = ack_q[2];
    assign rd_ack_o   = ack_q[3];
    assign disp_q_o   = disp_q_q;
    assign rd_q_o     = rd_q_q;
    assign mem_a_o    = mem_a_q;
    assign mem_d_o    = mem_dat_q;
    assign mem_we_o   = mem_we_q;
    assign mem_rd_o   = mem_rd_q;
    assign busy_o     = (state_q == FBARB_SLOT);
    assign gnt_id_o   = gnt_q;

    // A requester must keep REQ high for the whole of its slot.
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state_q == FBARB_SLOT) |-> req_v[gnt_q]);

    a_param_ok: assert property (@(posedge clk_i)
        (ACC_CYC >= 1) && (ACC_CYC <= 8) && (STARVE_MAX >= 1) && (STARVE_MAX <= 15));

endmodule
